hack_cpu_mc: RTL and testbench

HACK_CPU_MC -- requirements
Module: hack_cpu_mc

---
 rtl/hack_cpu_mc_if.sv | 37 +++
 rtl/hack_cpu_mc.sv | 180 ++++++++++++++++++
 tb/tb_hack_cpu_mc.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hack_cpu_mc_if.sv
// hack_cpu_mc_if: bus bundle between the Hack multi-cycle core and its memories.
// Parameters: DW data width, AW data-memory address width, PW program-counter width.
// Signals:
//   instr/instr_valid     program-memory instruction word and its qualifier
//   fetch_req/pc          program-memory request and program counter
//   inM/mem_ready         data-memory read data and transaction completion
//   readM/writeM          data-memory read / write requests
//   addressM/outM         data-memory address and write data
//   halted                core stopped on a self-loop
// Modports: master = core side, slave = memory side.
interface hack_cpu_mc_if #(
    parameter int DW = 16,
    parameter int AW = 15,
    parameter int PW = 15
);
    logic [DW-1:0] instr;
    logic          instr_valid;
    logic [DW-1:0] inM;
    logic          mem_ready;
    logic          fetch_req;
    logic [PW-1:0] pc;
    logic          readM;
    logic          writeM;
    logic [AW-1:0] addressM;
    logic [DW-1:0] outM;
    logic          halted;

    modport master (
        input  instr, instr_valid, inM, mem_ready,
        output fetch_req, pc, readM, writeM, addressM, outM, halted
    );

    modport slave (
        output instr, instr_valid, inM, mem_ready,
        input  fetch_req, pc, readM, writeM, addressM, outM, halted
    );
endinterface

// File: rtl/hack_cpu_mc.sv
// hack_cpu_mc: multi-cycle Hack CPU with wait-state capable program and data memory.
// Ports:
//   clk50m  system clock (only clock)
//   rst_n   asynchronous active-low reset
//   en25m   clock enable; nothing advances while low
//   bus     hack_cpu_mc_if.master (instruction fetch, data read/write, halt status)
// Every bus output comes straight from a register.
module hack_cpu_mc #(
    parameter int DW       = 16,
    parameter int AW       = 15,
    parameter int PW       = 15,
    parameter int HALT_DET = 1
) (
    input  logic          clk50m,
    input  logic          rst_n,
    input  logic          en25m,
    hack_cpu_mc_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_MREAD  = 3'd2,
        S_EXEC   = 3'd3,
        S_MWRITE = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t        r_state;
    logic [DW-1:0] r_ir;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_d;
    logic [DW-1:0] r_mdr;
    logic [PW-1:0] r_pc;
    logic [DW-1:0] r_out_m;
    // Holds A during MREAD and the write address (WADDR) during MWRITE.
    logic [AW-1:0] r_addr_m;
    logic          r_fetch_req;
    logic          r_read_m;
    logic          r_write_m;
    logic          r_halted;

    logic [DW-1:0] w_y;
    logic [DW-1:0] w_out;
    logic          w_zr;
    logic          w_ng;
    logic          w_jmp;
    logic          w_self_loop;
    logic [PW-1:0] w_pc_inc;
    logic [DW-1:0] w_a_load;

    // Standard Hack ALU; c = {zx, nx, zy, ny, f, no}.
    function automatic logic [DW-1:0] alu_f(
        input logic [DW-1:0] x_in,
        input logic [DW-1:0] y_in,
        input logic [5:0]    c
    );
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        logic [DW-1:0] o;
        x = c[5] ? {DW{1'b0}} : x_in;
        x = c[4] ? ~x : x;
        y = c[3] ? {DW{1'b0}} : y_in;
        y = c[2] ? ~y : y;
        o = c[1] ? (x + y) : (x & y);
        o = c[0] ? ~o : o;
        return o;
    endfunction

    // Datapath: ALU result, flags, jump decision and self-loop detection.
    always_comb begin
        w_y         = r_ir[12] ? r_mdr : r_a;
        w_out       = alu_f(r_d, w_y, r_ir[11:6]);
        w_zr        = (w_out == {DW{1'b0}});
        w_ng        = w_out[DW-1];
        w_jmp       = (r_ir[2] & w_ng) | (r_ir[1] & w_zr) | (r_ir[0] & ~w_ng & ~w_zr);
        w_pc_inc    = r_pc + {{(PW-1){1'b0}}, 1'b1};
        w_a_load    = {1'b0, r_ir[DW-2:0]};
        // Unconditional jump to its own address can never make progress.
        w_self_loop = (HALT_DET != 32'sd0) && (r_ir[2:0] == 3'b111) && (r_a[PW-1:0] == r_pc);
    end

    // Control FSM with registered bus outputs; r_a in EXEC is still A_old.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_FETCH;
            r_ir        <= {DW{1'b0}};
            r_a         <= {DW{1'b0}};
            r_d         <= {DW{1'b0}};
            r_mdr       <= {DW{1'b0}};
            r_pc        <= {PW{1'b0}};
            r_out_m     <= {DW{1'b0}};
            r_addr_m    <= {AW{1'b0}};
            r_fetch_req <= 1'b1;
            r_read_m    <= 1'b0;
            r_write_m   <= 1'b0;
            r_halted    <= 1'b0;
        end else if (en25m) begin
            case (r_state)
                S_FETCH: begin
                    if (bus.instr_valid) begin
                        r_ir        <= bus.instr;
                        r_fetch_req <= 1'b0;
                        r_state     <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!r_ir[15]) begin
                        r_a         <= w_a_load;
                        r_pc        <= w_pc_inc;
                        r_fetch_req <= 1'b1;
                        r_state     <= S_FETCH;
                    end else if (r_ir[12]) begin
                        r_read_m    <= 1'b1;
                        r_addr_m    <= r_a[AW-1:0];
                        r_state     <= S_MREAD;
                    end else begin
                        r_state     <= S_EXEC;
                    end
                end
                S_MREAD: begin
                    if (bus.mem_ready) begin
                        r_mdr    <= bus.inM;
                        r_read_m <= 1'b0;
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_ir[5]) begin
                        r_a <= w_out;
                    end
                    if (r_ir[4]) begin
                        r_d <= w_out;
                    end
                    if (r_ir[3]) begin
                        r_out_m  <= w_out;
                        r_addr_m <= r_a[AW-1:0];
                    end
                    r_pc <= w_jmp ? r_a[PW-1:0] : w_pc_inc;
                    if (w_self_loop) begin
                        r_halted    <= 1'b1;
                        r_state     <= S_HALT;
                    end else if (r_ir[3]) begin
                        r_write_m   <= 1'b1;
                        r_state     <= S_MWRITE;
                    end else begin
                        r_fetch_req <= 1'b1;
                        r_state     <= S_FETCH;
                    end
                end
                S_MWRITE: begin
                    if (bus.mem_ready) begin
                        r_write_m   <= 1'b0;
                        r_fetch_req <= 1'b1;
                        r_state     <= S_FETCH;
                    end
                end
                S_HALT: begin
                    r_halted <= 1'b1;
                end
                default: begin
                    r_fetch_req <= 1'b1;
                    r_read_m    <= 1'b0;
                    r_write_m   <= 1'b0;
                    r_halted    <= 1'b0;
                    r_state     <= S_FETCH;
                end
            endcase
        end
    end

    assign bus.fetch_req = r_fetch_req;
    assign bus.pc        = r_pc;
    assign bus.readM     = r_read_m;
    assign bus.writeM    = r_write_m;
    assign bus.addressM  = r_addr_m;
    assign bus.outM      = r_out_m;
    assign bus.halted    = r_halted;

endmodule

// File: tb/tb_hack_cpu_mc.sv
// tb_hack_cpu_mc: directed bench for hack_cpu_mc. A bench-side memory model serves
// fetches and data accesses; expected data-memory writes are queued when a program is
// loaded and compared when the core completes each write.
module tb_hack_cpu_mc;
    logic clk = 1'b0;
    logic rst_n;
    logic en25m;

    always #10 clk = ~clk;

    hack_cpu_mc_if #(.DW(16), .AW(15), .PW(15)) bus1();
    hack_cpu_mc_if #(.DW(16), .AW(15), .PW(15)) bus2();

    hack_cpu_mc #(.DW(16), .AW(15), .PW(15), .HALT_DET(1)) u_dut (
        .clk50m(clk), .rst_n(rst_n), .en25m(en25m), .bus(bus1)
    );

    hack_cpu_mc #(.DW(16), .AW(15), .PW(15), .HALT_DET(0)) u_dut_nohalt (
        .clk50m(clk), .rst_n(rst_n), .en25m(en25m), .bus(bus2)
    );

    typedef struct packed {
        logic [14:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t         sb[$];
    logic [15:0] prog[int];
    logic [15:0] dmem[int];

    int checks = 0;
    int errors = 0;
    int en_mode, rd_delay, wr_delay, rd_cnt, wr_cnt;
    int rd_total, wr_total, wr_done, fetch2_at1, both_viol, fetch_viol;
    logic [14:0] last_rd_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] prog_at(input logic [14:0] a);
        if (prog.exists(int'(a))) return prog[int'(a)];
        return 16'h0000;
    endfunction

    function automatic logic [15:0] dmem_at(input logic [14:0] a);
        if (dmem.exists(int'(a))) return dmem[int'(a)];
        return 16'h0000;
    endfunction

    task automatic clear_state();
        sb.delete();
        prog.delete();
        dmem.delete();
        rd_cnt = 0; wr_cnt = 0; rd_total = 0; wr_total = 0; wr_done = 0; fetch2_at1 = 0;
        rd_delay = 0; wr_delay = 0; last_rd_addr = 15'h0;
    endtask

    task automatic idle_inputs();
        en25m = 1'b0;
        bus1.instr = 16'h0; bus1.instr_valid = 1'b0; bus1.inM = 16'h0; bus1.mem_ready = 1'b0;
        bus2.instr = 16'h0; bus2.instr_valid = 1'b0; bus2.inM = 16'h0; bus2.mem_ready = 1'b0;
    endtask

    // One clock: respond to the core's requests at the falling edge.
    task automatic step();
        wr_t e;
        @(negedge clk);
        en25m = (en_mode == 0) ? 1'b1 : ~en25m;
        if (bus1.readM && bus1.writeM) both_viol++;
        if (bus1.fetch_req && (bus1.readM || bus1.writeM || bus1.halted)) fetch_viol++;
        if (en25m) begin
            bus1.instr       = prog_at(bus1.pc);
            bus1.instr_valid = bus1.fetch_req;
            bus1.mem_ready   = 1'b0;
            bus1.inM         = 16'h0;
            if (bus1.readM) begin
                rd_total++;
                last_rd_addr = bus1.addressM;
                bus1.inM = dmem_at(bus1.addressM);
                if (rd_cnt >= rd_delay) begin
                    bus1.mem_ready = 1'b1; rd_cnt = 0;
                end else begin
                    rd_cnt++;
                end
            end else if (bus1.writeM) begin
                wr_total++;
                if (wr_cnt >= wr_delay) begin
                    bus1.mem_ready = 1'b1; wr_cnt = 0; wr_done++;
                    dmem[int'(bus1.addressM)] = bus1.outM;
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $error("FAIL unexpected_write: observed addr 0x%0h data 0x%0h expected no write",
                               bus1.addressM, bus1.outM);
                    end else begin
                        e = sb.pop_front();
                        chk("write_addr", {17'h0, bus1.addressM}, {17'h0, e.addr});
                        chk("write_data", {16'h0, bus1.outM}, {16'h0, e.data});
                    end
                end else begin
                    wr_cnt++;
                end
            end
            bus2.instr       = (bus2.pc == 15'd0) ? 16'h0001 : 16'hEA87;
            bus2.instr_valid = bus2.fetch_req;
            bus2.mem_ready   = 1'b0;
            bus2.inM         = 16'h0;
            if (bus2.fetch_req && bus2.pc == 15'd1) fetch2_at1++;
        end else begin
            // Disabled cycle: drive junk that the core must ignore.
            bus1.instr = 16'($urandom); bus1.instr_valid = 1'b1;
            bus1.inM   = 16'($urandom); bus1.mem_ready   = 1'b1;
            bus2.instr = 16'($urandom); bus2.instr_valid = 1'b1;
            bus2.inM   = 16'($urandom); bus2.mem_ready   = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_en(input int n);
        int k = 0;
        int guard = 0;
        while (k < n && guard < 2000) begin
            step();
            if (en25m) k++;
            guard++;
        end
        if (k < n) begin
            checks++; errors++;
            $error("FAIL run_bound: observed %0d enabled cycles expected %0d", k, n);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        #2;
        chk("rst_pc", {17'h0, bus1.pc}, 32'h0);
        chk("rst_readM", {31'h0, bus1.readM}, 32'h0);
        chk("rst_writeM", {31'h0, bus1.writeM}, 32'h0);
        chk("rst_halted", {31'h0, bus1.halted}, 32'h0);
        chk("rst_addressM", {17'h0, bus1.addressM}, 32'h0);
        chk("rst_outM", {16'h0, bus1.outM}, 32'h0);
        clear_state();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_fetch_req", {31'h0, bus1.fetch_req}, 32'h1);
    endtask

    initial begin
        int found;
        rst_n = 1'b0;
        en_mode = 0; both_viol = 0; fetch_viol = 0;
        idle_inputs();
        clear_state();

        // A-instr, D=A, M=D, then self-loop halt; second core refetches instead.
        reset_dut();
        en_mode = 0;
        prog[0] = 16'h0005; prog[1] = 16'hEC10; prog[2] = 16'h0014; prog[3] = 16'hE308;
        prog[4] = 16'h0005; prog[5] = 16'hEA87;
        sb.push_back('{addr: 15'd20, data: 16'h0005});
        run_en(5);
        chk("lat5_pc", {17'h0, bus1.pc}, 32'd2);
        chk("lat5_fetch_req", {31'h0, bus1.fetch_req}, 32'h1);
        run_en(15);
        chk("halt_halted", {31'h0, bus1.halted}, 32'h1);
        chk("halt_fetch_req", {31'h0, bus1.fetch_req}, 32'h0);
        chk("halt_pc", {17'h0, bus1.pc}, 32'd5);
        run_en(4);
        chk("halt_pc_stable", {17'h0, bus1.pc}, 32'd5);
        chk("halt_no_req", {30'h0, bus1.readM, bus1.writeM}, 32'h0);
        chk("t1_sb_empty", sb.size(), 32'd0);
        chk("nohalt_halted", {31'h0, bus2.halted}, 32'h0);
        chk("nohalt_refetch", {31'h0, (fetch2_at1 >= 2)}, 32'h1);

        // D=M with three wait states and a toggling enable.
        reset_dut();
        en_mode = 1; rd_delay = 3;
        prog[0] = 16'h0007; prog[1] = 16'hFC10; prog[2] = 16'h0009; prog[3] = 16'hE308;
        dmem[7] = 16'h1234;
        sb.push_back('{addr: 15'd9, data: 16'h1234});
        run_en(20);
        chk("mread_held", rd_total, 32'd4);
        chk("mread_addr", {17'h0, last_rd_addr}, 32'd7);
        chk("t2_sb_empty", sb.size(), 32'd0);

        // AM=D+1 with D=9 at A=3: write uses old A, A becomes 10.
        reset_dut();
        en_mode = 0; wr_delay = 2;
        prog[0] = 16'h0009; prog[1] = 16'hEC10; prog[2] = 16'h0003; prog[3] = 16'hE7E8;
        prog[4] = 16'hEC10; prog[5] = 16'h0021; prog[6] = 16'hE308;
        sb.push_back('{addr: 15'd3,  data: 16'h000A});
        sb.push_back('{addr: 15'd33, data: 16'h000A});
        run_en(30);
        chk("mwrite_held", wr_total, 32'd6);
        chk("t3_no_read", rd_total, 32'd0);
        chk("t3_sb_empty", sb.size(), 32'd0);

        // Program counter wrap: jump to 0x7FFF, execute an A-instr there.
        reset_dut();
        en_mode = 0;
        prog[0] = 16'h7FFF; prog[1] = 16'hEA87; prog[32767] = 16'h0002;
        run_en(5);
        chk("pc_top", {17'h0, bus1.pc}, 32'h7FFF);
        run_en(2);
        chk("pc_wrap", {17'h0, bus1.pc}, 32'h0);

        // D=0x7FFF, D=D+1;JLT must jump (result negative).
        reset_dut();
        en_mode = 0;
        prog[0] = 16'h7FFF; prog[1] = 16'hEC10; prog[2] = 16'h0008; prog[3] = 16'hE7D4;
        prog[4] = 16'h0031; prog[5] = 16'hE308; prog[8] = 16'h0030; prog[9] = 16'hE308;
        sb.push_back('{addr: 15'd48, data: 16'h8000});
        run_en(18);
        chk("t5_sb_empty", sb.size(), 32'd0);

        // Reset during a stalled MWRITE with a toggling enable.
        reset_dut();
        en_mode = 1; wr_delay = 1000;
        prog[0] = 16'h0003; prog[1] = 16'hE308;
        found = 0;
        for (int g = 0; g < 80 && found == 0; g++) begin
            step();
            if (bus1.writeM) found = 1;
        end
        chk("mwrite_reached", found, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rstmid_writeM", {31'h0, bus1.writeM}, 32'h0);
        chk("rstmid_readM", {31'h0, bus1.readM}, 32'h0);
        chk("rstmid_pc", {17'h0, bus1.pc}, 32'h0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rstmid_fetch_req", {31'h0, bus1.fetch_req}, 32'h1);
        run_en(2);
        chk("rstmid_refetch_pc", {17'h0, bus1.pc}, 32'd1);
        chk("rstmid_no_write", wr_done, 32'd0);

        chk("never_read_and_write", both_viol, 32'd0);
        chk("fetch_only_in_fetch", fetch_viol, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
